// File: rtl/qpi_wb_pkg.sv
// Shared types and helpers for the QPI to Wishbone burst adapter.
package qpi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [255:0] ERR_FILL = '1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/qpi_wb_rfifo.sv
// Read-return FIFO: synchronous push/pop with flush, head always visible.
module qpi_wb_rfifo
    import qpi_wb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int FW    = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head,
    output logic [FW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;
    logic          do_pop;

    assign full   = (count == FW'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= bump(wptr);
            if (do_pop) rptr <= bump(rptr);
            unique case ({push, do_pop})
                2'b10:   count <= count + FW'(1);
                2'b01:   count <= count - FW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= din;
    end

    // Read credits keep the FIFO from ever being pushed while full.
    assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);

endmodule

// File: rtl/qpi_wb_burst_adapter.sv
// QPI cache line bursts to pipelined Wishbone B4 with outstanding accesses.
// Optional bus error support: define QPI_WB_ERR_EN.
module qpi_wb_burst_adapter
    import qpi_wb_pkg::*;
#(
    parameter int AW       = 23,
    parameter int DW       = 32,
    parameter int QPI_AW   = 25,
    parameter int MAX_OUT  = 4,
    parameter int RF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              qpi_do_read,
    input  logic              qpi_do_write,
    input  logic [QPI_AW-1:0] qpi_addr,
    input  logic [DW-1:0]     qpi_wdata,
    output logic [DW-1:0]     qpi_rdata,
    output logic              qpi_next_word,
    output logic              qpi_is_idle,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW/8-1:0]   o_wb_sel,
    output logic [DW-1:0]     o_wb_data,
`ifdef QPI_WB_ERR_EN
    input  logic              i_wb_err,
    input  logic              err_clr,
    output logic              err_sticky,
`endif
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic [DW-1:0]     i_wb_data
);

    localparam int OW = clog2(MAX_OUT + 1);
    localparam int FW = clog2(RF_DEPTH) + 1;

    state_t        state;
    state_t        state_d;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [AW-1:0] next_addr;
    logic [DW-1:0] data;
    logic [OW-1:0] outstanding;
    logic          slot_free;
    logic          accept;
    logic          done;
    logic          rd_load;
    logic          wr_load;
    logic          load;
    logic          push;
    logic          pop;
    logic          flush;
    logic          empty;
    logic [DW-1:0] push_data;
    logic [DW-1:0] head;
    logic [FW-1:0] fifo_count;
    logic [31:0]   wr_used;
    logic [31:0]   rd_used;
    logic          unused;

    assign unused    = ^qpi_addr[1:0];
    assign slot_free = !stb || !i_wb_stall;
    assign accept    = stb && !i_wb_stall;
    assign wr_used   = 32'(outstanding) + 32'(stb);
    assign rd_used   = wr_used + 32'(fifo_count);

`ifdef QPI_WB_ERR_EN
    assign done      = i_wb_ack || i_wb_err;
    assign push_data = i_wb_err ? ERR_FILL[DW-1:0] : i_wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_sticky <= 1'b0;
        else if (i_wb_err) err_sticky <= 1'b1;
        else if (err_clr) err_sticky <= 1'b0;
    end
`else
    assign done      = i_wb_ack;
    assign push_data = i_wb_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        rd_load = 1'b0;
        wr_load = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (qpi_do_read) state_d = RD;
                else if (qpi_do_write) state_d = WR;
            end
            RD: begin
                if (!qpi_do_read) begin
                    state_d = DRAIN;
                end else begin
                    rd_load = slot_free && (rd_used < 32'(RF_DEPTH));
                    pop     = !empty;
                end
            end
            WR: begin
                if (!qpi_do_write) state_d = DRAIN;
                else wr_load = slot_free && (wr_used < 32'(MAX_OUT));
            end
            DRAIN: begin
                if (!stb && outstanding == '0) state_d = IDLE;
            end
            default: ;
        endcase
    end

    assign load  = rd_load || wr_load;
    assign push  = done && (state == RD);
    assign flush = (state == DRAIN);

    // A pending strobe is only cleared once the slave has taken it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb         <= 1'b0;
            we          <= 1'b0;
            addr        <= '0;
            data        <= '0;
            next_addr   <= '0;
            outstanding <= '0;
        end else begin
            if (state == IDLE) next_addr <= AW'(qpi_addr[QPI_AW-1:2]);
            else if (load) next_addr <= next_addr + AW'(1);
            if (slot_free) stb <= load;
            if (load) begin
                addr <= next_addr;
                we   <= wr_load;
                data <= wr_load ? qpi_wdata : '0;
            end
            unique case ({accept, done})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase
        end
    end

    qpi_wb_rfifo #(
        .DW    (DW),
        .DEPTH (RF_DEPTH),
        .FW    (FW)
    ) u_rfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .count (fifo_count),
        .empty (empty)
    );

    assign qpi_rdata     = head;
    assign qpi_next_word = pop || wr_load;
    assign qpi_is_idle   = (state == IDLE) && !qpi_do_read && !qpi_do_write;
    assign o_wb_cyc      = stb || (outstanding != '0);
    assign o_wb_stb      = stb;
    assign o_wb_we       = we;
    assign o_wb_addr     = addr;
    assign o_wb_sel      = '1;
    assign o_wb_data     = data;

endmodule

// File: tb/tb_qpi_wb_burst_adapter.sv
// Bench for qpi_wb_burst_adapter: burst table plus reset/abort/error sequences.
// Build with QPI_WB_ERR_EN defined to also cover the bus error path.
module tb_qpi_wb_burst_adapter;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        qpi_do_read = 1'b0;
    logic        qpi_do_write = 1'b0;
    logic [24:0] qpi_addr = '0;
    logic [31:0] qpi_wdata = '0;
    logic [31:0] qpi_rdata;
    logic        qpi_next_word;
    logic        qpi_is_idle;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [22:0] o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_data;
`ifdef QPI_WB_ERR_EN
    logic        i_wb_err;
    logic        err_clr = 1'b0;
    logic        err_sticky;
`endif

    qpi_wb_burst_adapter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .qpi_do_read   (qpi_do_read),
        .qpi_do_write  (qpi_do_write),
        .qpi_addr      (qpi_addr),
        .qpi_wdata     (qpi_wdata),
        .qpi_rdata     (qpi_rdata),
        .qpi_next_word (qpi_next_word),
        .qpi_is_idle   (qpi_is_idle),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_addr     (o_wb_addr),
        .o_wb_sel      (o_wb_sel),
        .o_wb_data     (o_wb_data),
`ifdef QPI_WB_ERR_EN
        .i_wb_err      (i_wb_err),
        .err_clr       (err_clr),
        .err_sticky    (err_sticky),
`endif
        .i_wb_ack      (i_wb_ack),
        .i_wb_stall    (i_wb_stall),
        .i_wb_data     (i_wb_data)
    );

    always #5 clk = ~clk;

    int          errs = 0;
    int          checks = 0;
    logic        stall_en = 1'b0;
    logic        err_en = 1'b0;
    logic [22:0] err_addr = '0;

    // Slave model: fixed two-cycle ack latency, optional random stall.
    logic        p_v;
    logic        p_we;
    logic [22:0] p_a;
    int          outs;
    logic        acc;
    logic        wdone;

    assign acc = o_wb_cyc && o_wb_stb && !i_wb_stall;
`ifdef QPI_WB_ERR_EN
    assign wdone = i_wb_ack || i_wb_err;
`else
    assign wdone = i_wb_ack;
`endif

    function automatic logic [31:0] model(input logic [22:0] a);
        return {9'h0A5, a} ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] wv(input int i);
        return 32'h11111111 * 32'(i + 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_v        <= 1'b0;
            p_we       <= 1'b0;
            p_a        <= '0;
            i_wb_ack   <= 1'b0;
            i_wb_stall <= 1'b0;
            i_wb_data  <= '0;
            outs       <= 0;
`ifdef QPI_WB_ERR_EN
            i_wb_err   <= 1'b0;
`endif
        end else begin
            p_v  <= acc;
            p_a  <= o_wb_addr;
            p_we <= o_wb_we;
`ifdef QPI_WB_ERR_EN
            i_wb_ack <= p_v && !(err_en && p_a == err_addr);
            i_wb_err <= p_v && err_en && p_a == err_addr;
`else
            i_wb_ack <= p_v;
`endif
            i_wb_data  <= p_we ? 32'h0 : model(p_a);
            i_wb_stall <= stall_en && ($urandom_range(0, 1) == 1);
            outs       <= outs + (acc ? 1 : 0) - (wdone ? 1 : 0);
        end
    end

    logic [22:0] alog [256];
    logic [22:0] wla [64];
    logic [31:0] wld [64];
    int          an = 0;
    int          wn = 0;
    int          maxo = 0;
    int          drops = 0;
    logic        held = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (acc) begin
                alog[an % 256] <= o_wb_addr;
                an <= an + 1;
                if (o_wb_we) begin
                    wla[wn % 64] <= o_wb_addr;
                    wld[wn % 64] <= o_wb_data;
                    wn <= wn + 1;
                end
            end
            held <= o_wb_stb && i_wb_stall;
            if (held && !o_wb_stb) drops <= drops + 1;
            if (outs > maxo) maxo <= outs;
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag, output int extra);
        int c;
        c = 0;
        extra = 0;
        while (!qpi_is_idle && c < 300) begin
            @(negedge clk);
            c++;
            if (qpi_next_word) extra++;
        end
        check({tag, "_idle"}, {31'd0, qpi_is_idle}, 32'd1);
        check({tag, "_idle_outs"}, outs, 32'd0);
    endtask

    logic [31:0] rbuf [16];

    task automatic rd_burst(input logic [24:0] qa, input int n,
                            input logic [22:0] a0, input bit fly,
                            input string tag);
        int base, got, c, extra;
        logic [22:0] ea;
        logic [31:0] ed;
        base = an;
        got = 0;
        c = 0;
        @(posedge clk); #1;
        qpi_addr = qa;
        qpi_do_read = 1'b1;
        while (got < n && c < 300) begin
            @(negedge clk);
            c++;
            if (qpi_next_word) begin
                rbuf[got] = qpi_rdata;
                got++;
            end
        end
        @(posedge clk); #1;
        if (fly) check({tag, "_inflight"}, {31'd0, outs != 0 || o_wb_stb}, 32'd1);
        qpi_do_read = 1'b0;
        check({tag, "_words"}, got, n);
        wait_idle(tag, extra);
        check({tag, "_drain_pulses"}, extra, 32'd0);
        check({tag, "_accepts"}, {31'd0, (an - base) >= n}, 32'd1);
        for (int i = 0; i < n; i++) begin
            ea = a0 + 23'(i);
            ed = (err_en && ea == err_addr) ? 32'hFFFFFFFF : model(ea);
            check($sformatf("%s_addr%0d", tag, i), 32'(alog[(base + i) % 256]), 32'(ea));
            check($sformatf("%s_rdata%0d", tag, i), rbuf[i], ed);
        end
    endtask

    task automatic wr_burst(input logic [24:0] qa, input int n,
                            input logic [22:0] a0, input string tag);
        int base, idx, c, extra;
        logic [22:0] ea;
        base = wn;
        idx = 0;
        c = 0;
        @(posedge clk); #1;
        qpi_addr = qa;
        qpi_wdata = wv(0);
        qpi_do_write = 1'b1;
        while (idx < n && c < 400) begin
            @(negedge clk);
            c++;
            if (qpi_next_word) idx++;
            @(posedge clk); #1;
            qpi_wdata = wv(idx);
        end
        qpi_do_write = 1'b0;
        check({tag, "_pulses"}, idx, n);
        wait_idle(tag, extra);
        check({tag, "_drain_pulses"}, extra, 32'd0);
        check({tag, "_wcount"}, wn - base, n);
        for (int i = 0; i < n; i++) begin
            ea = a0 + 23'(i);
            check($sformatf("%s_waddr%0d", tag, i), 32'(wla[(base + i) % 64]), 32'(ea));
            check($sformatf("%s_wdata%0d", tag, i), wld[(base + i) % 64], wv(i));
        end
    endtask

    typedef struct {
        bit          wr;
        logic [24:0] qa;
        int          n;
        bit          stall;
        bit          fly;
        logic [22:0] a0;
    } burst_t;

    typedef struct {
        bit rd;
        bit wr;
        bit exp;
    } idle_t;

    burst_t tbl [6];
    idle_t  itbl [4];

    initial begin
        int c;
        int extra;

        tbl[0] = '{1'b0, 25'h0000100, 8, 1'b0, 1'b0, 23'h000040};
        tbl[1] = '{1'b1, 25'h0000200, 4, 1'b1, 1'b0, 23'h000080};
        tbl[2] = '{1'b0, 25'h1FFFFF8, 4, 1'b0, 1'b0, 23'h7FFFFE};
        tbl[3] = '{1'b1, 25'h1FFFFFC, 3, 1'b0, 1'b0, 23'h7FFFFF};
        tbl[4] = '{1'b0, 25'h0000013, 1, 1'b1, 1'b0, 23'h000004};
        tbl[5] = '{1'b0, 25'h0000400, 3, 1'b0, 1'b1, 23'h000100};
        itbl[0] = '{1'b0, 1'b0, 1'b1};
        itbl[1] = '{1'b1, 1'b0, 1'b0};
        itbl[2] = '{1'b0, 1'b1, 1'b0};
        itbl[3] = '{1'b1, 1'b1, 1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_ctrl", {28'd0, o_wb_cyc, o_wb_stb, o_wb_we, qpi_next_word}, 32'd0);
        check("rst_addr", 32'(o_wb_addr), 32'd0);
        check("rst_data", o_wb_data, 32'd0);
        check("rst_sel", 32'(o_wb_sel), 32'hF);
        check("rst_idle", {31'd0, qpi_is_idle}, 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            qpi_do_read = itbl[i].rd;
            qpi_do_write = itbl[i].wr;
            #1;
            check($sformatf("idle_vec%0d", i), {31'd0, qpi_is_idle}, {31'd0, itbl[i].exp});
            #1;
            qpi_do_read = 1'b0;
            qpi_do_write = 1'b0;
        end

        for (int i = 0; i < 6; i++) begin
            stall_en = tbl[i].stall;
            if (tbl[i].wr)
                wr_burst(tbl[i].qa, tbl[i].n, tbl[i].a0, $sformatf("b%0d", i));
            else
                rd_burst(tbl[i].qa, tbl[i].n, tbl[i].a0, tbl[i].fly, $sformatf("b%0d", i));
            stall_en = 1'b0;
        end

        // Both requests together: read takes priority.
        @(posedge clk); #1;
        qpi_addr = 25'h0000800;
        qpi_do_read = 1'b1;
        qpi_do_write = 1'b1;
        c = 0;
        while (!o_wb_stb && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("both_stb", {31'd0, o_wb_stb}, 32'd1);
        check("both_we", {31'd0, o_wb_we}, 32'd0);
        check("both_addr", 32'(o_wb_addr), 32'h200);
        @(posedge clk); #1;
        qpi_do_read = 1'b0;
        qpi_do_write = 1'b0;
        wait_idle("both", extra);

        // Asynchronous reset in the middle of a read burst.
        @(posedge clk); #1;
        qpi_addr = 25'h0001000;
        qpi_do_read = 1'b1;
        c = 0;
        while (!o_wb_stb && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("mid_stb", {31'd0, o_wb_stb}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {28'd0, o_wb_cyc, o_wb_stb, o_wb_we, qpi_next_word}, 32'd0);
        check("mid_rst_addr", 32'(o_wb_addr), 32'd0);
        check("mid_rst_idle_req", {31'd0, qpi_is_idle}, 32'd0);
        qpi_do_read = 1'b0;
        #1;
        check("mid_rst_idle", {31'd0, qpi_is_idle}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_burst(25'h0002000, 1, 23'h000800, 1'b0, "post_rst");

`ifdef QPI_WB_ERR_EN
        err_en = 1'b1;
        err_addr = 23'h000301;
        rd_burst(25'h0000C00, 3, 23'h000300, 1'b0, "err");
        err_en = 1'b0;
        check("err_sticky_set", {31'd0, err_sticky}, 32'd1);
        @(posedge clk); #1;
        check("err_sticky_hold", {31'd0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_sticky_clr", {31'd0, err_sticky}, 32'd0);
`endif

        check("max_outstanding", {31'd0, maxo <= MAX_OUT}, 32'd1);
        check("stb_withdrawn", drops, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
